// File: rtl/spart_pkg.sv
// Shared SPART types and constants, used by the transmitter and the future receiver.
package spart_pkg;

   // Transmit frame sequencing states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Legal range for the data-bits-per-frame parameter
   localparam int MIN_DATA_W = 5;
   localparam int MAX_DATA_W = 9;

   // Parity bit over a zero-extended payload; zero padding does not change the XOR.
   // odd=0 gives even parity (^data), odd=1 gives odd parity (~^data).
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/spart_tx_if.sv
// Host-side bundle of the SPART transmitter: write port, run-time config, status and serial pin.
interface spart_tx_if #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
);
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic [DIV_W-1:0]  baud_div;
   logic              parity_en;
   logic              parity_odd;
   logic              two_stop;
   logic              tx_rdy;
   logic              tx_busy;
   logic              tx_empty;
   logic              tx;

   // Host drives writes and config, observes status and the line
   modport master (
      output tx_start, tx_data, baud_div, parity_en, parity_odd, two_stop,
      input  tx_rdy, tx_busy, tx_empty, tx
   );

   // Transmitter consumes writes and config, drives status and the line
   modport slave (
      input  tx_start, tx_data, baud_div, parity_en, parity_odd, two_stop,
      output tx_rdy, tx_busy, tx_empty, tx
   );
endinterface

// File: rtl/spart_fifo.sv
// Synchronous TX FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without an occupancy counter. Pushes while full are dropped
// even if a pop happens on the same edge.
module spart_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] pop_data_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              push_ok_s;
   logic              pop_ok_s;

   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok_s  = push_i && !full_o;
   assign pop_ok_s   = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

   // Advance read/write pointers on accepted operations
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage write; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: FIFO-buffered frames with run-time baud divisor, optional
// parity and 1/2 stop bits. Config is latched at pop so each frame is atomic.
module spart_tx
   import spart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input logic       clk,
   input logic       rst_n,
   spart_tx_if.slave bus
);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   tx_state_t         state_q, state_d;
   logic [DIV_W-1:0]  cnt_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_eff_s;
   logic [3:0]        bit_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] fifo_data_s;
   logic              par_en_q, two_stop_q, par_q;
   logic              tx_q, tx_d;
   logic              fifo_full_s, fifo_empty_s;
   logic              pop_s, bit_end_s, last_data_s, last_stop_s, par_s;
   logic [MAX_DATA_W-1:0] par_in_s;

   spart_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (bus.tx_start),
      .push_data_i (bus.tx_data),
      .pop_i       (pop_s),
      .pop_data_o  (fifo_data_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   assign bit_end_s   = (cnt_q == {DIV_W{1'b0}});
   assign last_data_s = (bit_q == 4'(DATA_W-1));
   assign last_stop_s = (bit_q == {3'b000, two_stop_q});
   assign div_eff_s   = (bus.baud_div == {DIV_W{1'b0}}) ? DIV_ONE : bus.baud_div;

   assign bus.tx       = tx_q;
   assign bus.tx_rdy   = !fifo_full_s;
   assign bus.tx_busy  = (state_q != IDLE);
   assign bus.tx_empty = fifo_empty_s && (state_q == IDLE);

   // Pop when idle, or at the end of the last stop bit for a gapless next frame
   always_comb begin
      pop_s = 1'b0;
      if (fifo_empty_s) begin
         pop_s = 1'b0;
      end else if (state_q == IDLE) begin
         pop_s = 1'b1;
      end else if ((state_q == STOP) && bit_end_s && last_stop_s) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Parity of the word being popped, using the config sampled at pop time
   always_comb begin
      par_in_s                = {MAX_DATA_W{1'b0}};
      par_in_s[DATA_W-1:0]    = fifo_data_s;
      par_s                   = calc_parity(par_in_s, bus.parity_odd);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) state_d = START;
            else               state_d = IDLE;
         end
         START: begin
            if (bit_end_s) state_d = DATA;
            else           state_d = START;
         end
         DATA: begin
            if (bit_end_s && last_data_s) state_d = par_en_q ? PARITY : STOP;
            else                          state_d = DATA;
         end
         PARITY: begin
            if (bit_end_s) state_d = STOP;
            else           state_d = PARITY;
         end
         STOP: begin
            if (bit_end_s && last_stop_s) state_d = fifo_empty_s ? IDLE : START;
            else                          state_d = STOP;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM output logic: line level for the current bit
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         PARITY:  tx_d = par_q;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // Serial line flop; reset forces the line idle immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_q <= 1'b1;
      else        tx_q <= tx_d;
   end

   // Datapath: frame load on pop, baud countdown, bit counting and shifting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= {DATA_W{1'b0}};
         div_q      <= DIV_ONE;
         cnt_q      <= {DIV_W{1'b0}};
         bit_q      <= 4'd0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         par_q      <= 1'b0;
      end else if (pop_s) begin
         shift_q    <= fifo_data_s;
         div_q      <= div_eff_s;
         cnt_q      <= div_eff_s - DIV_ONE;
         bit_q      <= 4'd0;
         par_en_q   <= bus.parity_en;
         two_stop_q <= bus.two_stop;
         par_q      <= par_s;
      end else if (state_q != IDLE) begin
         if (bit_end_s) begin
            cnt_q <= div_q - DIV_ONE;
            case (state_q)
               DATA: begin
                  shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                  bit_q   <= last_data_s ? 4'd0 : bit_q + 4'd1;
               end
               STOP:    bit_q <= bit_q + 4'd1;
               default: bit_q <= bit_q;
            endcase
         end else begin
            cnt_q <= cnt_q - DIV_ONE;
         end
      end
   end

endmodule

// File: tb/tb_spart_tx.sv
module tb_spart_tx;
   import spart_pkg::*;

   localparam int DATA_W     = 8;
   localparam int DIV_W      = 16;
   localparam int FIFO_DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   spart_tx_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

   spart_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: expected per-cycle line levels for a burst
   logic              exp_q[$];
   logic [DATA_W-1:0] push_d[8];
   logic              rdy_obs[8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Append one frame's waveform, computed straight from the framing rules
   task automatic add_frame(input logic [DATA_W-1:0] d, input int div,
                            input bit pen, input bit odd, input bit two);
      int   reps;
      int   ones;
      logic bits[$];
      reps = (div == 0) ? 1 : div;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < DATA_W; i++) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pen) bits.push_back(odd ? (ones % 2 == 0) : (ones % 2 == 1));
      bits.push_back(1'b1);
      if (two) bits.push_back(1'b1);
      foreach (bits[i]) repeat (reps) exp_q.push_back(bits[i]);
   endtask

   // Push push_d[0..npush-1] on consecutive edges and compare the line and
   // busy flag each cycle against exp_q. Entered and left at a falling edge.
   task automatic run_seq(input int npush, input int chg_c, input bit chg_pen);
      int n;
      n = exp_q.size();
      for (int c = 0; c <= n + 2; c++) begin
         bus.tx_start = (c < npush);
         bus.tx_data  = (c < npush) ? push_d[c[2:0]] : {DATA_W{1'b0}};
         if (c == chg_c) bus.parity_en = chg_pen;
         @(posedge clk);
         @(negedge clk);
         if (c < 8) rdy_obs[c] = bus.tx_rdy;
         if (c == 0) begin
            check("tx_before_pop", bus.tx, 1);
            check("busy_before_pop", bus.tx_busy, 0);
         end else if (c == 1) begin
            check("tx_at_pop", bus.tx, 1);
            check("busy_at_pop", bus.tx_busy, 1);
         end else if (c < n + 2) begin
            check($sformatf("tx_cyc%0d", c - 2), bus.tx, exp_q[c-2]);
            check($sformatf("busy_cyc%0d", c - 2), bus.tx_busy, (c - 2) < (n - 1));
         end else begin
            check("tx_idle_end", bus.tx, 1);
            check("busy_end", bus.tx_busy, 0);
            check("empty_end", bus.tx_empty, 1);
            check("rdy_end", bus.tx_rdy, 1);
         end
      end
      bus.tx_start = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      logic [DATA_W-1:0] r0, r1, r2;
      int  dv;
      bit  pe, po, ts;

      bus.tx_start   = 1'b0;
      bus.tx_data    = {DATA_W{1'b0}};
      bus.baud_div   = 16'd4;
      bus.parity_en  = 1'b0;
      bus.parity_odd = 1'b0;
      bus.two_stop   = 1'b0;

      // 1 Reset held 5 cycles
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_tx", bus.tx, 1);
      check("rst_rdy", bus.tx_rdy, 1);
      check("rst_busy", bus.tx_busy, 0);
      check("rst_empty", bus.tx_empty, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // 2 8N1 div=4, 8'hCC
      push_d[0] = 8'hCC;
      add_frame(8'hCC, 4, 1'b0, 1'b0, 1'b0);
      run_seq(1, -1, 1'b0);

      // 3 Parity even / odd / two stop bits with 8'hA7
      bus.parity_en = 1'b1;
      push_d[0] = 8'hA7;
      add_frame(8'hA7, 4, 1'b1, 1'b0, 1'b0);
      run_seq(1, -1, 1'b1);
      bus.parity_odd = 1'b1;
      add_frame(8'hA7, 4, 1'b1, 1'b1, 1'b0);
      run_seq(1, -1, 1'b1);
      bus.parity_odd = 1'b0;
      bus.two_stop   = 1'b1;
      add_frame(8'hA7, 4, 1'b1, 1'b0, 1'b1);
      run_seq(1, -1, 1'b1);
      bus.parity_en = 1'b0;
      bus.two_stop  = 1'b0;

      // 4 Overflow: six pushes, 01..05 sent back-to-back, 06 dropped
      bus.baud_div = 16'd8;
      for (int i = 0; i < 6; i++) push_d[i] = DATA_W'(i + 1);
      for (int i = 0; i < 5; i++) add_frame(DATA_W'(i + 1), 8, 1'b0, 1'b0, 1'b0);
      run_seq(6, -1, 1'b0);
      check("ovf_rdy_occ3", rdy_obs[3], 1);
      check("ovf_rdy_full", rdy_obs[4], 0);
      check("ovf_rdy_drop", rdy_obs[5], 0);

      // 5 Reset during DATA bit 3 with a second word queued
      bus.baud_div = 16'd4;
      bus.tx_start = 1'b1;
      bus.tx_data  = 8'h37;
      @(posedge clk); @(negedge clk);
      bus.tx_data  = 8'h99;
      @(posedge clk); @(negedge clk);
      bus.tx_start = 1'b0;
      repeat (17) @(negedge clk);
      check("mid_bit3", bus.tx, 0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_tx", bus.tx, 1);
      check("mid_rst_empty", bus.tx_empty, 1);
      check("mid_rst_busy", bus.tx_busy, 0);
      check("mid_rst_rdy", bus.tx_rdy, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_d[0] = 8'h55;
      add_frame(8'h55, 4, 1'b0, 1'b0, 1'b0);
      run_seq(1, -1, 1'b0);

      // 6 parity_en toggled mid-frame affects only the next frame
      r0 = DATA_W'($urandom);
      r1 = DATA_W'($urandom);
      push_d[0] = r0;
      push_d[1] = r1;
      add_frame(r0, 4, 1'b0, 1'b0, 1'b0);
      add_frame(r1, 4, 1'b1, 1'b0, 1'b0);
      run_seq(2, 10, 1'b1);
      bus.parity_en = 1'b0;

      // 6b div=0 gives one-cycle bits
      bus.baud_div = 16'd0;
      r0 = DATA_W'($urandom);
      push_d[0] = r0;
      add_frame(r0, 0, 1'b0, 1'b0, 1'b0);
      run_seq(1, -1, 1'b0);

      // Randomized bursts of three frames with random config
      for (int k = 0; k < 4; k++) begin
         dv = int'($urandom_range(0, 5));
         pe = 1'($urandom);
         po = 1'($urandom);
         ts = 1'($urandom);
         r0 = DATA_W'($urandom);
         r1 = DATA_W'($urandom);
         r2 = DATA_W'($urandom);
         bus.baud_div   = DIV_W'(dv);
         bus.parity_en  = pe;
         bus.parity_odd = po;
         bus.two_stop   = ts;
         push_d[0] = r0;
         push_d[1] = r1;
         push_d[2] = r2;
         add_frame(r0, dv, pe, po, ts);
         add_frame(r1, dv, pe, po, ts);
         add_frame(r2, dv, pe, po, ts);
         run_seq(3, -1, pe);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
